// File: rtl/bus_pkg.sv
// Shared types and the round-robin pick used by the bus arbiter.
package bus_pkg;
  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // First set bit strictly after ptr, wrapping; ptr itself is checked last.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [SELW-1:0] ptr);
    pick_t           r;
    logic [SELW-1:0] cand;
    r = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = ptr + SELW'(i);
      if (!r.found && req[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_priority_encoder.sv
// Combinational round-robin priority encoder wrapping bus_pkg::rr_pick.
module rr_priority_encoder
  import bus_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            valid
);
  pick_t pick;

  assign pick  = rr_pick(req, ptr);
  assign idx   = pick.idx;
  assign valid = pick.found;
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 8-input bus multiplexer with a per-tenure burst cap.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAXBURST = 16,
  parameter int CNTW     = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EN,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [SELW-1:0] SEL,
  output logic            BUS_VALID,
  output logic            PREEMPT
);
  // The counter holds cycles-granted minus one, so MAXBURST = 256 still fits in 8 bits.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXBURST - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            valid_q, valid_d;
  logic            preempt_q, preempt_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [SELW-1:0] pick_idx;
  logic            pick_valid;

  rr_priority_encoder u_enc (
    .req   (REQ),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (EN && pick_valid) begin
          state_d = BUSY;
          gnt_d   = NREQ'(1) << pick_idx;
          sel_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        // Release wins over preempt when the owner drops on its last cycle.
        if (!REQ[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = sel_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
          ptr_d     = sel_q;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= SELW'(NREQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign GNT       = gnt_q;
  assign SEL       = sel_q;
  assign BUS_VALID = valid_q;
  assign PREEMPT   = preempt_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a tenure-level model.
module tb_bus_arbiter;
  localparam int MAXBURST = 16;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [7:0] REQ;
  logic [7:0] GNT;
  logic [2:0] SEL;
  logic       BUS_VALID;
  logic       PREEMPT;

  bus_arbiter #(.MAXBURST(MAXBURST), .CNTW(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .REQ       (REQ),
    .GNT       (GNT),
    .SEL       (SEL),
    .BUS_VALID (BUS_VALID),
    .PREEMPT   (PREEMPT)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: who owns the bus, for how long, and who owned it last
  int         m_owner;
  int         m_last;
  int         m_held;
  logic       m_pre;
  logic [2:0] m_sel;
  logic [2:0] exp_q[$];
  logic       prev_valid;
  int         pre_count;

  task automatic model_reset();
    m_owner    = -1;
    m_last     = 7;
    m_held     = 0;
    m_pre      = 1'b0;
    m_sel      = 3'd0;
    prev_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int idx;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (EN && REQ != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          idx = (m_last + k) % 8;
          if (m_owner < 0 && REQ[idx]) begin
            m_owner = idx;
            m_sel   = 3'(idx);
            m_held  = 1;
            exp_q.push_back(3'(idx));
          end
        end
      end
    end else if (!REQ[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_held == MAXBURST) begin
      m_pre   = 1'b1;
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_gnt;
    logic [2:0] exp_idx;
    exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    check("gnt", GNT, exp_gnt);
    check("sel", SEL, m_sel);
    check("bus_valid", BUS_VALID, m_owner >= 0);
    check("preempt", PREEMPT, m_pre);
    check("onehot", $countones(GNT) <= 1, 1);
    if (BUS_VALID && !prev_valid) begin
      check("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_idx = exp_q.pop_front();
        check("sb_order", SEL, exp_idx);
      end
    end
    if (PREEMPT) pre_count++;
    prev_valid = BUS_VALID;
  endtask

  // one clock: model advances on the edge, outputs are checked on the falling edge
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [7:0] req);
    @(negedge CLK);
    RST_N = 1'b0;
    REQ   = req;
    EN    = 1'b1;
    model_reset();
    @(negedge CLK);
    check("rst_gnt", GNT, 8'h00);
    check("rst_sel", SEL, 3'd0);
    check("rst_valid", BUS_VALID, 1'b0);
    check("rst_preempt", PREEMPT, 1'b0);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    EN    = 1'b1;
    REQ   = 8'h00;
    pre_count = 0;
    model_reset();

    // all requesters held: 0..7 then 0 again, one preempt per tenure
    do_reset(8'hFF);
    step();
    check("first_gnt", GNT, 8'h01);
    check("first_sel", SEL, 3'd0);
    pre_count = 0;
    steps(136);
    check("ff_wrap_gnt", GNT, 8'h01);
    check("ff_preempts", pre_count, 8);

    // two requesters, owner releases on its fifth grant cycle
    do_reset(8'h24);
    step();
    check("r24_gnt", GNT, 8'h04);
    check("r24_sel", SEL, 3'd2);
    pre_count = 0;
    steps(4);
    REQ = 8'h20;
    step();
    check("r24_release", GNT, 8'h00);
    step();
    check("r24_next_gnt", GNT, 8'h20);
    check("r24_next_sel", SEL, 3'd5);
    steps(3);
    check("r24_no_preempt", pre_count, 0);

    // single requester: 16 on, preempt + 1 idle, on again
    do_reset(8'h80);
    steps(16);
    check("r80_last_gnt", GNT, 8'h80);
    step();
    check("r80_preempt", PREEMPT, 1'b1);
    check("r80_idle", GNT, 8'h00);
    step();
    check("r80_regrant", GNT, 8'h80);

    // release on the MAXBURST cycle beats preempt
    do_reset(8'h08);
    steps(16);
    check("edge_gnt", GNT, 8'h08);
    REQ = 8'h00;
    step();
    check("edge_release_gnt", GNT, 8'h00);
    check("edge_release_pre", PREEMPT, 1'b0);

    // EN dropped mid-tenure: current tenure finishes, then bus stays idle
    REQ = 8'h08;
    step();
    check("en_gnt3", GNT, 8'h08);
    EN  = 1'b0;
    REQ = 8'h48;
    steps(24);
    check("en_low_idle", GNT, 8'h00);
    EN = 1'b1;
    step();
    check("en_high_gnt6", GNT, 8'h40);

    // asynchronous reset in the middle of a tenure owned by requester 4
    do_reset(8'h10);
    steps(4);
    check("ar_sel4", SEL, 3'd4);
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_gnt", GNT, 8'h00);
    check("ar_valid", BUS_VALID, 1'b0);
    check("ar_sel", SEL, 3'd0);
    check("ar_preempt", PREEMPT, 1'b0);
    model_reset();
    REQ = 8'h11;
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    check("ar_restart_gnt", GNT, 8'h01);

    // random traffic; REQ held for runs so tenures reach the burst limit
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) REQ = 8'($urandom_range(0, 255));
      EN = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
